branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Branch resolution and redirect controller for the pipelined RV32I core; it sits downstream of the branch comparator and consumes its `br_less`/`br_equal` flags. It drives the comparator's signedness select, evaluates the six conditional branches plus jumps in EX, and checks the outcome against a 2-bit-counter branch history table (BHT) queried by fetch. On a mispredict it issues a registered PC redirect and a multi-cycle pipeline flush.

## Interface
Parameters:
- `BHT_DEPTH`, default 16: BHT entries; power of two, ≥2. `IDX = $clog2(BHT_DEPTH)`.
- `FLUSH_CYCLES`, default 2: cycles `flush_o` stays high per redirect; range 1–7.

Ports:
- Clock and reset: single clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `if_pc_i`  in  32  fetch PC for prediction lookup.
- `pred_taken_o`  out  1  prediction for `if_pc_i`.
- `ex_valid_i`  in  1  control-flow instruction present in EX.
- `ex_is_jump_i`  in  1  JAL/JALR; 0 means conditional branch.
- `ex_pc_i`  in  32  PC of the EX instruction.
- `ex_funct3_i`  in  3  branch funct3.
- `ex_pred_taken_i`  in  1  prediction carried with the instruction.
- `ex_target_i`  in  32  computed target address.
- `br_unsigned_o`  out  1  to comparator; 1 for BLTU/BGEU.
- `br_less_i`, `br_equal_i`  in  1 each  comparator flags.
- `redirect_valid_o`  out  1  one-cycle redirect strobe.
- `redirect_pc_o`  out  32  correct next PC.
- `flush_o`  out  1  squash IF/ID.
- `br_illegal_o`  out  1  one-cycle strobe for a reserved funct3.

## Operation
- `br_unsigned_o = ex_funct3_i[1]`. Combinational and independent of `ex_valid_i`.
- Taken decision:
  - BEQ 000: `equal`. BNE 001: `!equal`.
  - BLT 100 and BLTU 110: `less`.
  - BGE 101 and BGEU 111: `!less`.
  - 010 and 011 are reserved: not taken, and `br_illegal_o` pulses.
  - Jumps are always taken.
- BHT entries are 2-bit saturating counters.
  - Index is `pc[IDX+1:2]`.
  - `pred_taken_o = bht[if_pc_i idx][1]`, combinational read.
- Accepted resolution: `ex_valid_i=1` while in state IDLE.
  - Conditional branch: increment the entry for `ex_pc_i` if taken, else decrement; saturate at 00 and 11.
  - Jumps: BHT is not updated.
  - Mispredict is `taken != ex_pred_taken_i`. On mispredict:
    - `redirect_pc_o` = `ex_target_i` if taken, else `ex_pc_i + 32'd4` (mod 2^32).
    - The FSM moves to FLUSH.
- FSM:
  - IDLE: on mispredict → FLUSH, with counter loaded to `FLUSH_CYCLES-1`.
  - FLUSH: counter decrements each cycle; at 0 → IDLE.
  - In FLUSH, `ex_valid_i` is ignored: no BHT update, no redirect, no illegal strobe.
- Reset values: state IDLE, every BHT entry 2'b01 (weakly not-taken), and all registered outputs 0:
  - `redirect_valid_o`, `redirect_pc_o`, `flush_o`, `br_illegal_o`.
- Reset asserted mid-FLUSH: outputs clear immediately (asynchronously) and the BHT reinitialises.

## Timing
- Resolution happens in cycle E; `redirect_valid_o`, `redirect_pc_o` and `br_illegal_o` are registered and valid in E+1 only.
- `flush_o` is high for exactly `FLUSH_CYCLES` cycles, E+1 through E+`FLUSH_CYCLES`.
- `redirect_pc_o` holds its last value when the strobe is low.
- BHT write takes effect at the E edge.
  - A same-cycle read of the same index returns the pre-update value (read-before-write).
- Correct prediction: no redirect, no flush; a new resolution is accepted every cycle.
- Back-to-back mispredicts: a second mispredict while in FLUSH is squashed. The first redirect wins.

## Structure
- Package `branch_pkg`:
  - funct3 localparams `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - `typedef logic [1:0] bht_ctr_t`.
  - `typedef enum logic {IDLE, FLUSH} br_state_e`.
  - `BHT_INIT = 2'b01`.
- Sub-module `bht_2bit`:
  - Parameterised by `BHT_DEPTH`.
  - One async read port, one sync update port, async reset init.
- Top-level logic: decode, mispredict detection, FSM/flush counter, output registers.

## Test plan
1. **Reset defaults:** release reset; `if_pc_i=0x100` → `pred_taken_o=0`, all outputs 0.
2. **BEQ taken, mispredicted:** `funct3=000`, `equal=1`, `pred=0`, `target=0x200` → E+1: `redirect_valid_o=1`, `redirect_pc_o=0x200`; `flush_o` high 2 cycles; entry 01→10, so `pred_taken_o` reads 1.
3. **BLTU not taken, predicted taken:** `funct3=110` → `br_unsigned_o=1`. `less=0`, `pred=1`, `ex_pc=0xFFFFFFFC` → `redirect_pc_o=0x00000000` (wrap).
4. **Saturation:** five taken BGE at `pc=0x40` with `less=0` → entry saturates at 11. One not-taken → 10; prediction stays 1.
5. **Flush squash:** mispredict, then another mispredicting branch in the next cycle → only one redirect; BHT entry of the second branch is unchanged. Also `funct3=010` → `br_illegal_o` pulse only when in IDLE.
6. **Reset mid-flush:** assert `rst_ni=0` during FLUSH → `flush_o=0` immediately; all entries predict not-taken after release.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit and its BHT.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } br_state_e;

    localparam bht_ctr_t BHT_INIT = 2'b01;

    function automatic bht_ctr_t bht_sat_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken && (ctr != 2'b11)) begin
            nxt = ctr + 2'b01;
        end else if (!taken && (ctr != 2'b00)) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch and one synchronous update port for EX.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 16,
    localparam int unsigned IDX = $clog2(BHT_DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [IDX-1:0] rd_idx_i,
    output bht_ctr_t       rd_ctr_o,
    input  logic           upd_en_i,
    input  logic [IDX-1:0] upd_idx_i,
    input  logic           upd_taken_i
);

    bht_ctr_t ctr_q [BHT_DEPTH];
    bht_ctr_t upd_ctr_d;

    // Read sees the stored value, so a same-cycle update is not forwarded.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        upd_ctr_d = bht_sat_next(ctr_q[upd_idx_i], upd_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= upd_ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and jumps in EX, trains the BHT, and issues a
// registered redirect plus a fixed-length flush on mispredict.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH    = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_jump_i,
    input  logic [31:0] ex_pc_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        br_unsigned_o,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        br_illegal_o
);

    localparam int unsigned IDX   = $clog2(BHT_DEPTH);
    localparam int unsigned CNT_W = 3;

    br_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             illegal_q, illegal_d;

    logic             taken;
    logic             reserved_f3;
    logic             accept;
    logic             mispredict;
    bht_ctr_t         rd_ctr;

    logic             unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[31:IDX+2], if_pc_i[1:0]};

    assign br_unsigned_o = ex_funct3_i[1];

    always_comb begin
        taken       = 1'b0;
        reserved_f3 = 1'b0;
        if (ex_is_jump_i) begin
            taken = 1'b1;
        end else begin
            unique case (ex_funct3_i)
                F3_BEQ:           taken = br_equal_i;
                F3_BNE:           taken = !br_equal_i;
                F3_BLT, F3_BLTU:  taken = br_less_i;
                F3_BGE, F3_BGEU:  taken = !br_less_i;
                default:          reserved_f3 = 1'b1;
            endcase
        end
    end

    // While flushing, the EX slot holds a squashed instruction and is ignored.
    assign accept     = ex_valid_i && (state_q == IDLE);
    assign mispredict = accept && (taken != ex_pred_taken_i);

    bht_2bit #(
        .BHT_DEPTH(BHT_DEPTH)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (if_pc_i[IDX+1:2]),
        .rd_ctr_o   (rd_ctr),
        .upd_en_i   (accept && !ex_is_jump_i),
        .upd_idx_i  (ex_pc_i[IDX+1:2]),
        .upd_taken_i(taken)
    );

    assign pred_taken_o = rd_ctr[1];

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        illegal_d        = accept && reserved_f3;

        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = taken ? ex_target_i : (ex_pc_i + 32'd4);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            illegal_q        <= illegal_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign br_illegal_o     = illegal_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: decode/redirect table plus BHT and
// flush-timing sequences.
module tb_branch_resolve_unit;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic        ex_valid_i;
    logic        ex_is_jump_i;
    logic [31:0] ex_pc_i;
    logic [2:0]  ex_funct3_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_target_i;
    logic        br_unsigned_o;
    logic        br_less_i;
    logic        br_equal_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        br_illegal_o;

    int total = 0;
    int bad   = 0;

    branch_resolve_unit #(
        .BHT_DEPTH(16),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_pc_i         (if_pc_i),
        .pred_taken_o    (pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_is_jump_i    (ex_is_jump_i),
        .ex_pc_i         (ex_pc_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .ex_target_i     (ex_target_i),
        .br_unsigned_o   (br_unsigned_o),
        .br_less_i       (br_less_i),
        .br_equal_i      (br_equal_i),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .br_illegal_o    (br_illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        is_jump;
        logic [2:0]  f3;
        logic        less;
        logic        equal;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] target;
        logic        exp_unsigned;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        ex_valid_i = 1'b0;
        rst_ni     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drive(input logic jmp, input logic [2:0] f3, input logic less,
                         input logic eq, input logic pred, input logic [31:0] pc,
                         input logic [31:0] tgt);
        ex_valid_i      = 1'b1;
        ex_is_jump_i    = jmp;
        ex_funct3_i     = f3;
        br_less_i       = less;
        br_equal_i      = eq;
        ex_pred_taken_i = pred;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
    endtask

    initial begin
        logic [31:0] last_pc;

        //          jmp   f3      lt    eq    pred  pc            target        uns   redir exp_pc        ill
        vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
        vecs[1]  = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 32'h0000_0110, 32'h0000_0280, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0380, 1'b0, 1'b1, 32'h0000_0380, 1'b0};
        vecs[3]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0480, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0580, 1'b0, 1'b1, 32'h0000_0504, 1'b0};
        vecs[6]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0700, 1'b1, 1'b1, 32'h0000_0700, 1'b0};
        vecs[7]  = '{1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0880, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 32'h0000_0900, 32'h0000_0980, 1'b1, 1'b1, 32'h0000_0904, 1'b1};
        vecs[9]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0A00, 32'h0000_0A80, 1'b0, 1'b1, 32'h0000_0A80, 1'b0};
        vecs[10] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 32'h0000_0B00, 32'h0000_0B80, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

        rst_ni          = 1'b0;
        if_pc_i         = 32'h0000_0100;
        ex_valid_i      = 1'b0;
        ex_is_jump_i    = 1'b0;
        ex_pc_i         = '0;
        ex_funct3_i     = '0;
        ex_pred_taken_i = 1'b0;
        ex_target_i     = '0;
        br_less_i       = 1'b0;
        br_equal_i      = 1'b0;

        // Reset defaults
        do_reset();
        chk("rst_pred", 32'(pred_taken_o), 32'd0);
        chk("rst_redir_v", 32'(redirect_valid_o), 32'd0);
        chk("rst_redir_pc", redirect_pc_o, 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_ill", 32'(br_illegal_o), 32'd0);

        // BEQ taken mispredict: read-before-write, redirect, 2-cycle flush
        drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200);
        #1;
        chk("beq_pred_same_cycle", 32'(pred_taken_o), 32'd0);
        tick();
        ex_valid_i = 1'b0;
        chk("beq_redir_v", 32'(redirect_valid_o), 32'd1);
        chk("beq_redir_pc", redirect_pc_o, 32'h0000_0200);
        chk("beq_flush1", 32'(flush_o), 32'd1);
        chk("beq_pred_after", 32'(pred_taken_o), 32'd1);
        tick();
        chk("beq_redir_v_e2", 32'(redirect_valid_o), 32'd0);
        chk("beq_flush2", 32'(flush_o), 32'd1);
        tick();
        chk("beq_flush3", 32'(flush_o), 32'd0);

        // Decode / redirect table
        do_reset();
        last_pc = 32'd0;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].is_jump, vecs[i].f3, vecs[i].less, vecs[i].equal,
                  vecs[i].pred, vecs[i].pc, vecs[i].target);
            #1;
            chk($sformatf("v%0d_unsigned", i), 32'(br_unsigned_o), 32'(vecs[i].exp_unsigned));
            tick();
            ex_valid_i = 1'b0;
            if (vecs[i].exp_redir) last_pc = vecs[i].exp_pc;
            chk($sformatf("v%0d_redir_v", i), 32'(redirect_valid_o), 32'(vecs[i].exp_redir));
            chk($sformatf("v%0d_redir_pc", i), redirect_pc_o, last_pc);
            chk($sformatf("v%0d_ill", i), 32'(br_illegal_o), 32'(vecs[i].exp_ill));
            chk($sformatf("v%0d_flush_e1", i), 32'(flush_o), 32'(vecs[i].exp_redir));
            tick();
            chk($sformatf("v%0d_redir_v_e2", i), 32'(redirect_valid_o), 32'd0);
            chk($sformatf("v%0d_ill_e2", i), 32'(br_illegal_o), 32'd0);
            chk($sformatf("v%0d_flush_e2", i), 32'(flush_o), 32'(vecs[i].exp_redir));
            tick();
            chk($sformatf("v%0d_flush_e3", i), 32'(flush_o), 32'd0);
        end

        // Saturation at pc 0x40: five correct taken BGE, back-to-back
        do_reset();
        if_pc_i = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080);
            tick();
            chk($sformatf("sat_noredir%0d", i), 32'(redirect_valid_o), 32'd0);
            chk($sformatf("sat_noflush%0d", i), 32'(flush_o), 32'd0);
        end
        ex_valid_i = 1'b0;
        #1;
        chk("sat_pred_11", 32'(pred_taken_o), 32'd1);
        drive(1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080);
        tick();
        ex_valid_i = 1'b0;
        chk("sat_nt_redir_v", 32'(redirect_valid_o), 32'd1);
        chk("sat_nt_redir_pc", redirect_pc_o, 32'h0000_0044);
        chk("sat_pred_10", 32'(pred_taken_o), 32'd1);
        tick();
        tick();
        drive(1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080);
        tick();
        ex_valid_i = 1'b0;
        chk("sat_pred_01", 32'(pred_taken_o), 32'd0);
        tick();
        tick();

        // Flush squash and illegal gating
        do_reset();
        if_pc_i = 32'h0000_0104;
        drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200);
        tick();
        chk("sq_redir_v1", 32'(redirect_valid_o), 32'd1);
        chk("sq_redir_pc1", redirect_pc_o, 32'h0000_0200);
        drive(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0300);
        tick();
        chk("sq_redir_v2", 32'(redirect_valid_o), 32'd0);
        chk("sq_redir_pc2", redirect_pc_o, 32'h0000_0200);
        chk("sq_flush2", 32'(flush_o), 32'd1);
        chk("sq_bht_unchanged", 32'(pred_taken_o), 32'd0);
        drive(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_0400);
        tick();
        chk("sq_ill_in_flush", 32'(br_illegal_o), 32'd0);
        chk("sq_flush3", 32'(flush_o), 32'd0);
        chk("sq_redir_v3", 32'(redirect_valid_o), 32'd0);
        drive(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_0400);
        tick();
        ex_valid_i = 1'b0;
        chk("sq_ill_idle", 32'(br_illegal_o), 32'd1);
        chk("sq_ill_no_redir", 32'(redirect_valid_o), 32'd0);
        tick();
        chk("sq_ill_one_cycle", 32'(br_illegal_o), 32'd0);

        // Reset asserted mid-flush
        do_reset();
        if_pc_i = 32'h0000_0100;
        drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200);
        tick();
        ex_valid_i = 1'b0;
        chk("rmf_flush_before", 32'(flush_o), 32'd1);
        chk("rmf_pred_before", 32'(pred_taken_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rmf_flush_async", 32'(flush_o), 32'd0);
        chk("rmf_redir_v_async", 32'(redirect_valid_o), 32'd0);
        chk("rmf_redir_pc_async", redirect_pc_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if_pc_i = 32'(i * 4);
            #1;
            chk($sformatf("rmf_pred_idx%0d", i), 32'(pred_taken_o), 32'd0);
        end
        tick();
        chk("rmf_flush_after", 32'(flush_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
